// File: rtl/glyph_pixel_pipe.sv
// glyph_pixel_pipe: turns VGA timing counts into RRRGGGBB pixels by looking up
// a 40x30 map of 16x16 glyphs held in external sync-read tile RAM and glyph ROM.
// Every output, including the delayed syncs, trails its input by 5 clocks.
module glyph_pixel_pipe #(
    parameter logic [9:0] H_START  = 10'd145,
    parameter logic [9:0] V_START  = 10'd32,
    parameter int         TILES_X  = 40,
    parameter int         TILES_Y  = 30,
    parameter logic [7:0] BG_COLOR = 8'h00
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        bright,
    input  logic        hSync,
    input  logic        vSync,
    output logic [10:0] tile_addr,
    input  logic [7:0]  tile_data,
    output logic [8:0]  glyph_addr,
    input  logic [15:0] glyph_data,
    output logic [7:0]  rgb,
    output logic        hSync_out,
    output logic        vSync_out,
    output logic        bright_out,
    output logic        frame_tick
);

    localparam logic [5:0] TILES_X_LIM = 6'(TILES_X);
    localparam logic [5:0] TILES_Y_LIM = 6'(TILES_Y);

    // Syncs travel as {bright, vSync, hSync}; idle means blanked with both syncs high.
    localparam logic [2:0] SYNC_IDLE = 3'b011;

    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [5:0]  tile_x;
    logic [5:0]  tile_y;
    logic        pix_valid;
    logic [10:0] row_base;
    logic        pixel_on;
    logic [7:0]  palette_color;

    logic [10:0] tile_addr_d,  tile_addr_q;
    logic        v1_d,         v1_q;
    logic [3:0]  col1_d,       col1_q;
    logic [3:0]  row1_d,       row1_q;
    logic [2:0]  sync1_d,      sync1_q;

    logic        v2_d,         v2_q;
    logic [3:0]  col2_d,       col2_q;
    logic [3:0]  row2_d,       row2_q;
    logic [2:0]  sync2_d,      sync2_q;

    logic [8:0]  glyph_addr_d, glyph_addr_q;
    logic [2:0]  colour3_d,    colour3_q;
    logic        v3_d,         v3_q;
    logic [3:0]  col3_d,       col3_q;
    logic [2:0]  sync3_d,      sync3_q;

    logic        v4_d,         v4_q;
    logic [3:0]  col4_d,       col4_q;
    logic [2:0]  colour4_d,    colour4_q;
    logic [2:0]  sync4_d,      sync4_q;

    logic [7:0]  rgb_d,        rgb_q;
    logic [2:0]  sync5_d,      sync5_q;
    logic        vs_prev_d,    vs_prev_q;
    logic        frame_tick_d, frame_tick_q;

    // Stage 1: pixel/tile coordinates, visibility test and tile RAM address (ty*40 as two shifts).
    always_comb begin
        pix_x       = hCount - H_START;
        pix_y       = vCount - V_START;
        tile_x      = pix_x[9:4];
        tile_y      = pix_y[9:4];
        pix_valid   = bright && (tile_x < TILES_X_LIM) && (tile_y < TILES_Y_LIM);
        row_base    = ({5'd0, tile_y} << 5) + ({5'd0, tile_y} << 3);
        tile_addr_d = pix_valid ? (row_base + {5'd0, tile_x}) : 11'd0;
        v1_d        = pix_valid;
        col1_d      = pix_x[3:0];
        row1_d      = pix_y[3:0];
        sync1_d     = {bright, vSync, hSync};
    end

    // Stage 2: hold the pixel context while the tile RAM read is in flight.
    always_comb begin
        v2_d    = v1_q;
        col2_d  = col1_q;
        row2_d  = row1_q;
        sync2_d = sync1_q;
    end

    // Stage 3: tile byte arrives; form the glyph ROM address and latch the colour index.
    always_comb begin
        glyph_addr_d = v2_q ? {tile_data[4:0], row2_q} : 9'd0;
        colour3_d    = tile_data[7:5];
        v3_d         = v2_q;
        col3_d       = col2_q;
        sync3_d      = sync2_q;
    end

    // Stage 4: hold the pixel context while the glyph ROM read is in flight.
    always_comb begin
        v4_d      = v3_q;
        col4_d    = col3_q;
        colour4_d = colour3_q;
        sync4_d   = sync3_q;
    end

    // Stage 5: pick the glyph bit for this column, colour it, and force black when blanked.
    always_comb begin
        pixel_on = glyph_data[4'd15 - col4_q];
        case (colour4_q)
            3'd0:    palette_color = 8'h00;
            3'd1:    palette_color = 8'h03;
            3'd2:    palette_color = 8'h1C;
            3'd3:    palette_color = 8'h1F;
            3'd4:    palette_color = 8'hE0;
            3'd5:    palette_color = 8'hE3;
            3'd6:    palette_color = 8'hFC;
            default: palette_color = 8'hFF;
        endcase
        rgb_d   = !v4_q ? 8'h00 : (pixel_on ? palette_color : BG_COLOR);
        sync5_d = sync4_q;
    end

    // Falling-edge detect on the delayed vSync; the history bit idles high so reset never ticks.
    always_comb begin
        vs_prev_d    = sync5_q[1];
        frame_tick_d = vs_prev_q & ~sync5_q[1];
    end

    // All pipeline registers, synchronously cleared to the blanked/idle state.
    always_ff @(posedge clk) begin
        if (clear) begin
            tile_addr_q  <= 11'd0;
            v1_q         <= 1'b0;
            col1_q       <= 4'd0;
            row1_q       <= 4'd0;
            sync1_q      <= SYNC_IDLE;
            v2_q         <= 1'b0;
            col2_q       <= 4'd0;
            row2_q       <= 4'd0;
            sync2_q      <= SYNC_IDLE;
            glyph_addr_q <= 9'd0;
            colour3_q    <= 3'd0;
            v3_q         <= 1'b0;
            col3_q       <= 4'd0;
            sync3_q      <= SYNC_IDLE;
            v4_q         <= 1'b0;
            col4_q       <= 4'd0;
            colour4_q    <= 3'd0;
            sync4_q      <= SYNC_IDLE;
            rgb_q        <= 8'h00;
            sync5_q      <= SYNC_IDLE;
            vs_prev_q    <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            tile_addr_q  <= tile_addr_d;
            v1_q         <= v1_d;
            col1_q       <= col1_d;
            row1_q       <= row1_d;
            sync1_q      <= sync1_d;
            v2_q         <= v2_d;
            col2_q       <= col2_d;
            row2_q       <= row2_d;
            sync2_q      <= sync2_d;
            glyph_addr_q <= glyph_addr_d;
            colour3_q    <= colour3_d;
            v3_q         <= v3_d;
            col3_q       <= col3_d;
            sync3_q      <= sync3_d;
            v4_q         <= v4_d;
            col4_q       <= col4_d;
            colour4_q    <= colour4_d;
            sync4_q      <= sync4_d;
            rgb_q        <= rgb_d;
            sync5_q      <= sync5_d;
            vs_prev_q    <= vs_prev_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign tile_addr  = tile_addr_q;
    assign glyph_addr = glyph_addr_q;
    assign rgb        = rgb_q;
    assign bright_out = sync5_q[2];
    assign vSync_out  = sync5_q[1];
    assign hSync_out  = sync5_q[0];
    assign frame_tick = frame_tick_q;

endmodule
